// File: rtl/cache_ctrl_pkg.sv
// Shared types and widths for the direct-mapped write-back cache controller.
package cache_ctrl_pkg;

  localparam int ADDRWIDTH    = 16;
  localparam int WORDWIDTH    = 16;
  localparam int IOSTATEWIDTH = 2;
  localparam int ERRWIDTH     = 2;

  typedef enum logic [IOSTATEWIDTH-1:0] {
    IDEL = 2'd0,
    RD   = 2'd1,
    WT   = 2'd2
  } io_op_e;

  localparam logic [ERRWIDTH-1:0] ERR_OK      = 2'd0;
  localparam logic [ERRWIDTH-1:0] ERR_TIMEOUT = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_RESP = 2'd3
  } cache_state_e;

endpackage

// File: rtl/cache_ctrl_if.sv
// Core load/store port, memBus requester port and error status of one cache.
interface cache_ctrl_if;
  import cache_ctrl_pkg::*;

  logic                 cpuReq;
  logic                 cpuWe;
  logic [ADDRWIDTH-1:0] cpuAddr;
  logic [WORDWIDTH-1:0] cpuWdata;
  logic [WORDWIDTH-1:0] cpuRdata;
  logic                 cpuReady;
  io_op_e               rwToBus;
  logic [ADDRWIDTH-1:0] addrToBus;
  logic [WORDWIDTH-1:0] dataToBus;
  logic [WORDWIDTH-1:0] dataFromBus;
  logic                 rdEnFromBus;
  logic                 wbDoneFromBus;
  logic [ERRWIDTH-1:0]  errReg;

  // the cache controller itself
  modport cache (
    input  cpuReq, cpuWe, cpuAddr, cpuWdata, dataFromBus, rdEnFromBus, wbDoneFromBus,
    output cpuRdata, cpuReady, rwToBus, addrToBus, dataToBus, errReg
  );

  // the core issuing loads/stores
  modport master (
    output cpuReq, cpuWe, cpuAddr, cpuWdata,
    input  cpuRdata, cpuReady, errReg
  );

  // the memBus side answering RD/WT
  modport slave (
    input  rwToBus, addrToBus, dataToBus,
    output dataFromBus, rdEnFromBus, wbDoneFromBus
  );

endinterface

// File: rtl/cache_ctrl_array.sv
// Tag/valid/dirty/data storage: one async read port, one write port; only valid/dirty are reset.
module cache_ctrl_array
  import cache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = ADDRWIDTH - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [WORDWIDTH-1:0]  rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [WORDWIDTH-1:0]  wr_data_i,
  input  logic                  wr_dirty_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [TAG_BITS-1:0]  tag_mem  [LINES];
  logic [WORDWIDTH-1:0] data_mem [LINES];
  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_mem[wr_idx_i]  <= wr_tag_i;
      data_mem[wr_idx_i] <= wr_data_i;
    end
  end

  // every write installs a line, so valid is simply set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_data_o  = data_mem[rd_idx_i];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller, one word per line.
// Hits are served locally; misses become a victim WT then a RD fill on memBus.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TIMEOUT    = 1023
) (
  input  logic         clk,
  input  logic         reset,
  cache_ctrl_if.cache  cif
);

  // state  | meaning
  // IDLE   | accept a core request, serve hits and clean store misses
  // WB     | WT of the dirty victim on memBus
  // FILL   | RD of the requested word (one IDEL cycle first when entered from WB)
  // RESP   | return filled word to the core

  localparam int TAG_BITS = ADDRWIDTH - INDEX_BITS;
  localparam int TMO_W    = 10;

  cache_state_e          state_q;
  io_op_e                rw_q;
  logic [ADDRWIDTH-1:0]  addr_q;
  logic [WORDWIDTH-1:0]  wdata_q;
  logic [WORDWIDTH-1:0]  rdata_q;
  logic                  ready_q;
  logic [ERRWIDTH-1:0]   err_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  seen_busy_q;
  logic                  rd_pend_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   cpu_tag;
  logic                  rd_valid, rd_dirty;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [WORDWIDTH-1:0]  rd_data;
  logic                  hit, victim_dirty, req_new;
  logic                  bus_done, in_xfer, xfer_done, tmo_hit;
  logic                  wr_en, wr_dirty;
  logic [WORDWIDTH-1:0]  wr_data;

  assign idx          = cif.cpuAddr[INDEX_BITS-1:0];
  assign cpu_tag      = cif.cpuAddr[ADDRWIDTH-1:INDEX_BITS];
  assign hit          = rd_valid && (rd_tag == cpu_tag);
  assign victim_dirty = rd_valid && rd_dirty;
  // the request is still held during the ready pulse, so it is ignored that cycle
  assign req_new      = (state_q == S_IDLE) && cif.cpuReq && !ready_q;
  assign bus_done     = (state_q == S_WB) ? cif.wbDoneFromBus : cif.rdEnFromBus;
  assign in_xfer      = (state_q == S_WB) || ((state_q == S_FILL) && !rd_pend_q);
  assign xfer_done    = in_xfer && bus_done && seen_busy_q;
  assign tmo_hit      = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    wr_en    = 1'b0;
    wr_data  = cif.cpuWdata;
    wr_dirty = 1'b1;
    if (req_new && cif.cpuWe && (hit || !victim_dirty)) begin
      wr_en = 1'b1;
    end
    if ((state_q == S_WB) && xfer_done && cif.cpuWe) begin
      wr_en = 1'b1;
    end
    if ((state_q == S_FILL) && xfer_done) begin
      wr_en    = 1'b1;
      wr_data  = cif.dataFromBus;
      wr_dirty = 1'b0;
    end
  end

  cache_ctrl_array #(
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (wr_en),
    .wr_idx_i   (idx),
    .wr_tag_i   (cpu_tag),
    .wr_data_i  (wr_data),
    .wr_dirty_i (wr_dirty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rw_q        <= IDEL;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= ERR_OK;
      tmo_q       <= '0;
      seen_busy_q <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_new) begin
            if (hit) begin
              if (!cif.cpuWe) rdata_q <= rd_data;
              ready_q <= 1'b1;
            end else if (victim_dirty) begin
              state_q     <= S_WB;
              rw_q        <= WT;
              addr_q      <= {rd_tag, idx};
              wdata_q     <= rd_data;
              seen_busy_q <= 1'b0;
              tmo_q       <= '0;
            end else if (cif.cpuWe) begin
              ready_q <= 1'b1;
            end else begin
              state_q     <= S_FILL;
              rw_q        <= RD;
              addr_q      <= cif.cpuAddr;
              seen_busy_q <= 1'b0;
              tmo_q       <= '0;
            end
          end
        end
        S_WB, S_FILL: begin
          if ((state_q == S_FILL) && rd_pend_q) begin
            rw_q        <= RD;
            addr_q      <= cif.cpuAddr;
            seen_busy_q <= 1'b0;
            tmo_q       <= '0;
            rd_pend_q   <= 1'b0;
          end else if (xfer_done) begin
            rw_q <= IDEL;
            if (state_q == S_FILL) begin
              state_q <= S_RESP;
            end else if (cif.cpuWe) begin
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q   <= S_FILL;
              rd_pend_q <= 1'b1;
            end
          end else if (tmo_hit) begin
            err_q   <= ERR_TIMEOUT;
            rw_q    <= IDEL;
            state_q <= S_IDLE;
            tmo_q   <= tmo_q + TMO_W'(1);
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
            // done=1 while idle/not granted is not completion; a 0 must come first
            if (!bus_done) seen_busy_q <= 1'b1;
          end
        end
        S_RESP: begin
          rdata_q <= rd_data;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cif.cpuRdata  = rdata_q;
  assign cif.cpuReady  = ready_q;
  assign cif.rwToBus   = rw_q;
  assign cif.addrToBus = addr_q;
  assign cif.dataToBus = wdata_q;
  assign cif.errReg    = err_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: memBus model with hold/delay, reference memory and line model.
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
  } bus_op_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_ctrl_if cif();

  cache_ctrl #(.INDEX_BITS(6), .TIMEOUT(1023)) dut (
    .clk   (clk),
    .reset (reset),
    .cif   (cif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] bus_mem [65536];
  logic [15:0] ref_mem [65536];
  logic [9:0]  m_tag   [64];
  logic        m_valid [64];
  logic        m_dirty [64];

  bus_op_t     bus_log[$];
  int          bus_delay = 100;
  int          bus_hold  = 0;

  logic        req_active = 1'b0;
  logic        cur_we     = 1'b0;
  logic [15:0] exp_rdata  = '0;
  logic        exp_err    = 1'b0;
  logic        err_free   = 1'b0;
  logic [15:0] last_rdata = '0;
  int          ready_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // memBus: keeps done high for bus_hold cycles, then low for bus_delay-1 cycles, then done
  logic [1:0]  bm_op;
  logic [15:0] bm_addr, bm_data;
  logic        bm_abort;
  initial begin
    cif.rdEnFromBus   = 1'b1;
    cif.wbDoneFromBus = 1'b1;
    cif.dataFromBus   = '0;
    forever begin
      @(posedge clk); #1;
      if (cif.rwToBus != IDEL) begin
        bm_op    = cif.rwToBus;
        bm_addr  = cif.addrToBus;
        bm_data  = cif.dataToBus;
        bm_abort = 1'b0;
        bus_log.push_back('{bm_op, bm_addr, bm_data});
        for (int k = 0; k < bus_hold && !bm_abort; k++) begin
          @(posedge clk); #1;
          if (cif.rwToBus == IDEL) bm_abort = 1'b1;
        end
        if (!bm_abort) begin
          if (bm_op == WT) cif.wbDoneFromBus = 1'b0;
          else cif.rdEnFromBus = 1'b0;
          for (int k = 1; k < bus_delay && !bm_abort; k++) begin
            @(posedge clk); #1;
            if (cif.rwToBus == IDEL) bm_abort = 1'b1;
          end
        end
        if (!bm_abort) begin
          if (bm_op == WT) bus_mem[bm_addr] = bm_data;
          else cif.dataFromBus = bus_mem[bm_addr];
        end
        cif.wbDoneFromBus = 1'b1;
        cif.rdEnFromBus   = 1'b1;
        if (!bm_abort) begin
          for (int k = 0; k < 50 && cif.rwToBus != IDEL; k++) begin
            @(posedge clk); #1;
          end
        end
      end
    end
  end

  // per-cycle compare against the reference expectations
  logic [1:0]  prev_rw;
  logic [15:0] prev_addr, prev_data;
  logic        prev_ready;
  always @(negedge clk) begin
    if (reset) begin
      prev_rw    = IDEL;
      prev_ready = 1'b0;
    end else begin
      if (cif.cpuReady) begin
        ready_seen++;
        check("ready_without_request", req_active, 1'b1);
        check("ready_pulse_width", prev_ready, 1'b0);
        if (!cur_we) check("cpuRdata", cif.cpuRdata, exp_rdata);
      end
      if (!err_free) check("errReg", cif.errReg, exp_err);
      if (prev_rw != IDEL && cif.rwToBus != IDEL) begin
        check("bus_idel_gap", cif.rwToBus, prev_rw);
        check("addrToBus_stable", cif.addrToBus, prev_addr);
        if (prev_rw == WT) check("dataToBus_stable", cif.dataToBus, prev_data);
      end
      prev_rw    = cif.rwToBus;
      prev_addr  = cif.addrToBus;
      prev_data  = cif.dataToBus;
      prev_ready = cif.cpuReady;
    end
  end

  task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d,
                        input bit b2b, input string tname);
    logic [5:0]  idx;
    logic [9:0]  tg;
    logic [15:0] vaddr;
    bit          hit, vd;
    bus_op_t     exp_ops[$];
    int          exp_lat, lat, t;
    idx   = a[5:0];
    tg    = a[15:6];
    vaddr = {m_tag[idx], idx};
    hit   = m_valid[idx] && (m_tag[idx] == tg);
    vd    = m_valid[idx] && m_dirty[idx];
    t     = bus_hold + bus_delay;
    if (hit) exp_lat = 1;
    else begin
      if (vd) exp_ops.push_back('{WT, vaddr, ref_mem[vaddr]});
      if (!we) exp_ops.push_back('{RD, a, 16'h0});
      if (we) exp_lat = vd ? t + 1 : 1;
      else    exp_lat = vd ? 2 * t + 3 : t + 2;
    end
    if (b2b) exp_lat++;
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (we) m_dirty[idx] = 1'b1;

    if (!b2b) begin @(posedge clk); #1; end
    bus_log.delete();
    exp_rdata    = ref_mem[a];
    if (we) ref_mem[a] = d;
    cur_we       = we;
    req_active   = 1'b1;
    cif.cpuReq   = 1'b1;
    cif.cpuWe    = we;
    cif.cpuAddr  = a;
    cif.cpuWdata = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!cif.cpuReady && lat < 5000);
    last_rdata = cif.cpuRdata;
    check({tname, " latency"}, lat, exp_lat);
    @(negedge clk); #1;
    cif.cpuReq = 1'b0;
    req_active = 1'b0;
    check({tname, " bus_op_count"}, bus_log.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < bus_log.size(); i++) begin
      check({tname, " bus_op"}, bus_log[i].op, exp_ops[i].op);
      check({tname, " bus_addr"}, bus_log[i].addr, exp_ops[i].addr);
      if (exp_ops[i].op == WT) check({tname, " bus_wdata"}, bus_log[i].data, exp_ops[i].data);
    end
  endtask

  int          lat, rdy0, bad;
  logic        r_we;
  logic [15:0] r_a, r_d;
  bit          r_b2b;

  initial begin
    for (int i = 0; i < 65536; i++) bus_mem[i] = 16'(i) ^ 16'h5A5A;
    bus_mem[16'h0040] = 16'hBEEF;
    for (int i = 0; i < 65536; i++) ref_mem[i] = bus_mem[i];
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
    end
    cif.cpuReq = 1'b0; cif.cpuWe = 1'b0; cif.cpuAddr = '0; cif.cpuWdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset rwToBus", cif.rwToBus, IDEL);
    check("reset cpuReady", cif.cpuReady, 1'b0);
    check("reset cpuRdata", cif.cpuRdata, 16'h0);
    check("reset errReg", cif.errReg, 2'd0);
    check("reset addrToBus", cif.addrToBus, 16'h0);
    check("reset dataToBus", cif.dataToBus, 16'h0);
    @(negedge clk);
    reset = 1'b0;

    // 1: cold load, then hit
    do_req(1'b0, 16'h0040, 16'h0, 1'b0, "t1_cold_load");
    check("t1 fill data", last_rdata, 16'hBEEF);
    do_req(1'b0, 16'h0040, 16'h0, 1'b0, "t1_hit");
    check("t1 hit no bus", bus_log.size(), 0);
    do_req(1'b0, 16'h0040, 16'h0, 1'b1, "t1_hit_b2b");

    // 2: clean store miss, then dirty conflict load
    do_req(1'b1, 16'h0041, 16'h1234, 1'b0, "t2_store");
    check("t2 store no bus", bus_log.size(), 0);
    do_req(1'b0, 16'h0081, 16'h0, 1'b0, "t2_conflict");
    check("t2 two ops", bus_log.size(), 2);
    if (bus_log.size() == 2) begin
      check("t2 first WT", bus_log[0].op, WT);
      check("t2 WT addr", bus_log[0].addr, 16'h0041);
      check("t2 WT data", bus_log[0].data, 16'h1234);
      check("t2 then RD", bus_log[1].op, RD);
      check("t2 RD addr", bus_log[1].addr, 16'h0081);
    end

    // 3: bus holds done high for 20 cycles before starting
    bus_hold = 20;
    do_req(1'b0, 16'h0200, 16'h0, 1'b0, "t3_hold");
    check("t3 data", last_rdata, 16'h0200 ^ 16'h5A5A);
    bus_hold = 0;

    // 5: bus never drops done -> timeout
    bus_hold = 5000;
    err_free = 1'b1;
    @(posedge clk); #1;
    bus_log.delete();
    cur_we = 1'b0; req_active = 1'b1;
    cif.cpuReq = 1'b1; cif.cpuWe = 1'b0; cif.cpuAddr = 16'h00C0;
    rdy0 = ready_seen;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (cif.errReg == 2'd0 && lat < 1100);
    cif.cpuReq = 1'b0;
    check("t5 timeout window", (lat >= 1023 && lat <= 1025), 1'b1);
    if (!(lat >= 1023 && lat <= 1025)) $display("t5 timeout after %0d cycles", lat);
    check("t5 errReg", cif.errReg, 2'd1);
    check("t5 rwToBus idel", cif.rwToBus, IDEL);
    check("t5 no ready", ready_seen - rdy0, 0);
    check("t5 one RD", bus_log.size(), 1);
    exp_err = 1'b1;
    @(negedge clk); #1;
    req_active = 1'b0;
    err_free   = 1'b0;
    bus_hold   = 0;
    repeat (20) @(posedge clk);
    #1;
    check("t5 errReg sticky", cif.errReg, 2'd1);
    do_req(1'b0, 16'h0200, 16'h0, 1'b0, "t5_line_unchanged");

    // 4: reset 30 cycles into a fill
    @(posedge clk); #1;
    cur_we = 1'b0; req_active = 1'b1;
    cif.cpuReq = 1'b1; cif.cpuWe = 1'b0; cif.cpuAddr = 16'h0100;
    repeat (30) @(posedge clk);
    #1;
    check("t4 in FILL", cif.rwToBus, RD);
    reset = 1'b1;
    #1;
    check("t4 async idel", cif.rwToBus, IDEL);
    check("t4 err cleared", cif.errReg, 2'd0);
    cif.cpuReq = 1'b0; req_active = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i < 64; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    for (int i = 0; i < 65536; i++) ref_mem[i] = bus_mem[i];
    do_req(1'b0, 16'h0200, 16'h0, 1'b0, "t4_miss_after_reset");
    check("t4 miss RD", bus_log.size(), 1);

    // 6: random traffic over a few conflicting tags, then flush
    bus_delay = 2;
    for (int n = 0; n < 300; n++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_a   = 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
      r_d   = 16'($urandom_range(0, 65535));
      r_b2b = ($urandom_range(0, 1) == 1);
      do_req(r_we, r_a, r_d, r_b2b, "t6_rand");
    end
    for (int i = 0; i < 64; i++) begin
      if (m_valid[i] && m_dirty[i])
        do_req(1'b0, {m_tag[i] + 10'd1, 6'(i)}, 16'h0, 1'b0, "t6_flush");
    end
    bad = 0;
    for (int i = 0; i < 65536; i++) if (bus_mem[i] !== ref_mem[i]) bad++;
    check("t6 memory after flush", bad, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
